// File: rtl/ctrl_pipe_regs.sv
// Control-word pipeline registers ID/EX, EX/MEM and MEM/WB for the 5-stage core,
// with load-use bubble insertion, branch/jump squash and a saturating stall counter.
module ctrl_pipe_regs #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [9:0]        id_ctrl,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              br_taken_i,
    output logic [9:0]        ex_ctrl,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_valid,
    output logic [4:0]        mem_ctrl,
    output logic [REG_AW-1:0] mem_dst,
    output logic              mem_valid,
    output logic [1:0]        wb_ctrl,
    output logic [REG_AW-1:0] wb_dst,
    output logic              stall_o,
    output logic              if_flush_o,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int B_REGDST  = 9;
    localparam int B_MEMREAD = 5;
    localparam int B_JUMP    = 2;

    logic [9:0]        ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
    logic              ex_valid_q, ex_valid_d;
    logic [4:0]        mem_ctrl_q, mem_ctrl_d;
    logic [REG_AW-1:0] mem_dst_q, mem_dst_d;
    logic              mem_valid_q, mem_valid_d;
    logic [1:0]        wb_ctrl_q, wb_ctrl_d;
    logic [REG_AW-1:0] wb_dst_q, wb_dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              id_jump;
    logic [REG_AW-1:0] id_dst;
    logic              dst_hit;
    logic              haz;

    assign id_jump = id_ctrl[B_JUMP];
    assign id_dst  = id_ctrl[B_REGDST] ? id_rd : id_rt;
    assign dst_hit = (ex_dst_q == id_rs) || (ex_dst_q == id_rt);

    // A jump never stalls: it only redirects fetch, so it must not wait on a load.
    assign haz = id_valid && !id_jump && ex_valid_q
              && ex_ctrl_q[B_MEMREAD]
              && (ex_dst_q != '0) && dst_hit;

    assign stall_o    = haz && !br_taken_i;
    assign if_flush_o = br_taken_i || (id_valid && id_jump);

    always_comb begin
        ex_valid_d  = id_valid;
        ex_ctrl_d   = id_valid ? id_ctrl : '0;
        ex_dst_d    = id_valid ? id_dst : '0;
        mem_valid_d = ex_valid_q;
        mem_ctrl_d  = ex_ctrl_q[7:3];
        mem_dst_d   = ex_dst_q;
        wb_ctrl_d   = mem_ctrl_q[4:3];
        wb_dst_d    = mem_dst_q;
        cnt_d       = cnt_q;
        if (br_taken_i) begin
            ex_valid_d  = 1'b0;
            ex_ctrl_d   = '0;
            ex_dst_d    = '0;
            mem_valid_d = 1'b0;
            mem_ctrl_d  = '0;
            mem_dst_d   = '0;
        end else if (haz) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_dst_d   = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q   <= '0;
            ex_dst_q    <= '0;
            ex_valid_q  <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_dst_q   <= '0;
            mem_valid_q <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_dst_q    <= '0;
            cnt_q       <= '0;
        end else begin
            ex_ctrl_q   <= ex_ctrl_d;
            ex_dst_q    <= ex_dst_d;
            ex_valid_q  <= ex_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_dst_q   <= mem_dst_d;
            mem_valid_q <= mem_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_dst_q    <= wb_dst_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_ctrl   = ex_ctrl_q;
    assign ex_dst    = ex_dst_q;
    assign ex_valid  = ex_valid_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign mem_dst   = mem_dst_q;
    assign mem_valid = mem_valid_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign wb_dst    = wb_dst_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed bench for ctrl_pipe_regs: advance, load-use stall, branch squash,
// jump flush, counter saturation (narrow instance) and mid-flight reset.
module tb_ctrl_pipe_regs;

    localparam logic [9:0] ADD = 10'b1001000010;
    localparam logic [9:0] LW  = 10'b0111100000;
    localparam logic [9:0] BEQ = 10'b0000001001;
    localparam logic [9:0] JMP = 10'b0000000100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [9:0] id_ctrl;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       br_taken_i;

    logic [9:0]  ex_ctrl, ex_ctrl_s;
    logic [4:0]  ex_dst, ex_dst_s, mem_dst, mem_dst_s, wb_dst, wb_dst_s;
    logic        ex_valid, ex_valid_s, mem_valid, mem_valid_s;
    logic [4:0]  mem_ctrl, mem_ctrl_s;
    logic [1:0]  wb_ctrl, wb_ctrl_s;
    logic        stall_o, stall_o_s, if_flush_o, if_flush_o_s;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_pipe_regs #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .br_taken_i(br_taken_i),
        .ex_ctrl(ex_ctrl), .ex_dst(ex_dst), .ex_valid(ex_valid),
        .mem_ctrl(mem_ctrl), .mem_dst(mem_dst), .mem_valid(mem_valid),
        .wb_ctrl(wb_ctrl), .wb_dst(wb_dst), .stall_o(stall_o),
        .if_flush_o(if_flush_o), .stall_cnt(stall_cnt)
    );

    ctrl_pipe_regs #(.REG_AW(5), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .br_taken_i(br_taken_i),
        .ex_ctrl(ex_ctrl_s), .ex_dst(ex_dst_s), .ex_valid(ex_valid_s),
        .mem_ctrl(mem_ctrl_s), .mem_dst(mem_dst_s), .mem_valid(mem_valid_s),
        .wb_ctrl(wb_ctrl_s), .wb_dst(wb_dst_s), .stall_o(stall_o_s),
        .if_flush_o(if_flush_o_s), .stall_cnt(stall_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [9:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        id_valid = 1'b1;
        id_ctrl  = c;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        id_ctrl  = '0;
        id_rs    = '0;
        id_rt    = '0;
        id_rd    = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        br_taken_i = 1'b0;
        idle();
        step();
        step();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        rst_n = 1'b1;
        step();

        // add $3,$1,$2
        issue(ADD, 5'd1, 5'd2, 5'd3);
        step();
        idle();
        chk("add_ex_dst", 32'(ex_dst), 32'd3);
        chk("add_ex_ctrl", 32'(ex_ctrl), 32'(ADD));
        chk("add_ex_valid", 32'(ex_valid), 32'd1);
        step();
        chk("add_mem_ctrl", 32'(mem_ctrl), 32'h08);
        chk("add_mem_dst", 32'(mem_dst), 32'd3);
        step();
        chk("add_wb_ctrl", 32'(wb_ctrl), 32'd1);
        chk("add_wb_dst", 32'(wb_dst), 32'd3);

        // lw $5,0($1) ; add $6,$5,$2
        issue(LW, 5'd1, 5'd5, 5'd0);
        step();
        chk("lw_ex_dst", 32'(ex_dst), 32'd5);
        issue(ADD, 5'd5, 5'd2, 5'd6);
        #1;
        chk("lu_stall", 32'(stall_o), 32'd1);
        chk("lu_flush", 32'(if_flush_o), 32'd0);
        step();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_mem_ctrl", 32'(mem_ctrl), 32'h1C);
        chk("lu_stall_drop", 32'(stall_o), 32'd0);
        step();
        idle();
        chk("lu_add_late_dst", 32'(ex_dst), 32'd6);
        chk("lu_add_late_valid", 32'(ex_valid), 32'd1);
        chk("lu_wb_lw", 32'(wb_ctrl), 32'd3);

        // lw $0 then use of $0
        issue(LW, 5'd1, 5'd0, 5'd0);
        step();
        issue(ADD, 5'd0, 5'd2, 5'd7);
        #1;
        chk("r0_no_stall", 32'(stall_o), 32'd0);
        step();
        idle();
        chk("r0_cnt", 32'(stall_cnt), 32'd1);
        chk("r0_ex_dst", 32'(ex_dst), 32'd7);
        step();
        step();
        step();

        // beq ; lw $5 ; add $6,$5 with branch taken in MEM
        issue(BEQ, 5'd1, 5'd2, 5'd0);
        step();
        issue(LW, 5'd1, 5'd5, 5'd0);
        step();
        chk("br_mem_branch", 32'(mem_ctrl), 32'h01);
        issue(ADD, 5'd5, 5'd2, 5'd6);
        br_taken_i = 1'b1;
        #1;
        chk("br_flush", 32'(if_flush_o), 32'd1);
        chk("br_no_stall", 32'(stall_o), 32'd0);
        step();
        br_taken_i = 1'b0;
        idle();
        chk("br_ex_valid", 32'(ex_valid), 32'd0);
        chk("br_mem_valid", 32'(mem_valid), 32'd0);
        chk("br_mem_ctrl", 32'(mem_ctrl), 32'd0);
        chk("br_cnt", 32'(stall_cnt), 32'd1);
        step();
        step();

        // jump: flush, advances, never stalls even against a load in EX
        issue(LW, 5'd1, 5'd5, 5'd0);
        step();
        issue(JMP, 5'd5, 5'd5, 5'd0);
        #1;
        chk("j_flush", 32'(if_flush_o), 32'd1);
        chk("j_no_stall", 32'(stall_o), 32'd0);
        step();
        idle();
        chk("j_ex_ctrl", 32'(ex_ctrl), 32'(JMP));
        chk("j_cnt", 32'(stall_cnt), 32'd1);
        #1;
        chk("j_flush_drop", 32'(if_flush_o), 32'd0);
        step();
        step();

        // five load-use pairs
        for (int i = 0; i < 5; i++) begin
            issue(LW, 5'd1, 5'd5, 5'd0);
            step();
            issue(ADD, 5'd2, 5'd5, 5'd6);
            step();
            step();
        end
        idle();
        chk("sat_small_cnt", 32'(stall_cnt_s), 32'd3);
        chk("sat_big_cnt", 32'(stall_cnt), 32'd6);

        // mid-flight reset
        issue(LW, 5'd1, 5'd5, 5'd0);
        step();
        issue(ADD, 5'd5, 5'd2, 5'd6);
        #1;
        chk("mr_pre_stall", 32'(stall_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_ex_valid", 32'(ex_valid), 32'd0);
        chk("mr_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("mr_mem_valid", 32'(mem_valid), 32'd0);
        chk("mr_mem_ctrl", 32'(mem_ctrl), 32'd0);
        chk("mr_wb_ctrl", 32'(wb_ctrl), 32'd0);
        chk("mr_cnt", 32'(stall_cnt), 32'd0);
        chk("mr_stall", 32'(stall_o), 32'd0);
        step();
        rst_n = 1'b1;
        issue(ADD, 5'd1, 5'd2, 5'd9);
        step();
        idle();
        chk("post_ex_dst", 32'(ex_dst), 32'd9);
        step();
        chk("post_wb_early", 32'(wb_ctrl), 32'd0);
        step();
        chk("post_wb_ctrl", 32'(wb_ctrl), 32'd1);
        chk("post_wb_dst", 32'(wb_dst), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
